// File: rtl/tc_ram_dual_read.sv
// tc_ram_dual_read: byte-masked write port plus two write-first synchronous read ports; define TC_RAM_CLEAR_EN for a post-reset zeroing sweep
module tc_ram_dual_read #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 8,
  parameter int DEPTH = 256,
  localparam int LANES = DATA_WIDTH / 8
) (
  input  logic                  clk,
  input  logic                  rst,
  output logic                  busy,
  input  logic                  save,
  input  logic [LANES-1:0]      save_mask,
  input  logic [ADDR_WIDTH-1:0] save_addr,
  input  logic [DATA_WIDTH-1:0] in,
  input  logic                  load0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic [DATA_WIDTH-1:0] out0,
  input  logic                  load1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic [DATA_WIDTH-1:0] out1
);
  logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};
  logic [DATA_WIDTH-1:0] bmask, cur, merged, rd0, rd1;
  logic wr_ok;
  function automatic logic ok(input logic [ADDR_WIDTH-1:0] a);
    return {1'b0, a} < (ADDR_WIDTH+1)'(DEPTH);
  endfunction
  always_comb begin
    bmask = '0;
    for (int i = 0; i < LANES; i++) bmask[8*i +: 8] = {8{save_mask[i]}};
  end
  assign wr_ok  = save && !busy && ok(save_addr) && |save_mask;
  assign cur    = ok(save_addr) ? mem[save_addr] : '0;
  assign merged = (in & bmask) | (cur & ~bmask);
  // Write-first: a read hitting the word being written sees the merged result
  assign rd0 = !ok(addr0) ? '0 : (wr_ok && addr0 == save_addr) ? merged : mem[addr0];
  assign rd1 = !ok(addr1) ? '0 : (wr_ok && addr1 == save_addr) ? merged : mem[addr1];
  always_ff @(posedge clk) begin
    if (rst || busy) begin
      out0 <= '0;
      out1 <= '0;
    end else begin
      if (load0) out0 <= rd0;
      if (load1) out1 <= rd1;
    end
  end
`ifdef TC_RAM_CLEAR_EN
  typedef enum logic {CLEAR, IDLE} state_t;
  state_t state, state_n;
  logic [ADDR_WIDTH-1:0] ptr, ptr_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= CLEAR;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end
  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    if (state == CLEAR) begin
      ptr_n   = ptr + 1'b1;
      state_n = (ptr == ADDR_WIDTH'(DEPTH - 1)) ? IDLE : CLEAR;
    end
  end
  assign busy = state == CLEAR;
  always_ff @(posedge clk) begin
    if (busy) mem[ptr] <= '0;
    else if (wr_ok) mem[save_addr] <= merged;
  end
`else
  assign busy = 1'b0;
  always_ff @(posedge clk) begin
    if (wr_ok) mem[save_addr] <= merged;
  end
`endif
endmodule

// File: tb/tb_tc_ram_dual_read.sv
// tb_tc_ram_dual_read: scoreboard bench for tc_ram_dual_read (16-bit words, 200 entries)
module tb_tc_ram_dual_read;
  localparam int DEPTH = 200;
  logic clk = 0, rst = 1, busy, save = 0, load0 = 0, load1 = 0;
  logic [1:0] save_mask = 0;
  logic [7:0] save_addr = 0, addr0 = 0, addr1 = 0;
  logic [15:0] in = 0, out0, out1, exp0, exp1, last0 = 0, last1 = 0;
  logic [15:0] m [DEPTH] = '{default: '0};
  logic [15:0] q0 [$], q1 [$];
  int ntests = 0, nfail = 0;

  tc_ram_dual_read #(.DATA_WIDTH(16), .ADDR_WIDTH(8), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .busy(busy), .save(save), .save_mask(save_mask),
    .save_addr(save_addr), .in(in), .load0(load0), .addr0(addr0), .out0(out0),
    .load1(load1), .addr1(addr1), .out1(out1));

  always #5 clk = ~clk;

  task automatic drive(input logic s, input logic [1:0] mk, input logic [7:0] sa,
                       input logic [15:0] d, input logic l0, input logic [7:0] a0,
                       input logic l1, input logic [7:0] a1);
    save = s; save_mask = mk; save_addr = sa; in = d;
    load0 = l0; addr0 = a0; load1 = l1; addr1 = a1;
    if (s && sa < DEPTH)
      for (int i = 0; i < 2; i++) if (mk[i]) m[sa][8*i +: 8] = d[8*i +: 8];
    if (l0) last0 = a0 < DEPTH ? m[a0] : 16'h0;
    if (l1) last1 = a1 < DEPTH ? m[a1] : 16'h0;
    q0.push_back(last0);
    q1.push_back(last1);
    @(posedge clk); #1;
    save = 0; load0 = 0; load1 = 0;
  endtask

  task automatic wait_sweep(input string name);
    int n = 0;
    while (busy && n < 1000) begin @(posedge clk); #1; n++; end
    ntests++;
    if (n != DEPTH) begin nfail++; $display("FAIL %s busy cycles got %0d exp %0d", name, n, DEPTH); end
    for (int i = 0; i < DEPTH; i++) m[i] = '0;
  endtask

  task automatic test_reset;
    rst = 1;
    repeat (5) @(posedge clk);
    #1;
    ntests++;
    if (out0 !== 16'h0 || out1 !== 16'h0) begin nfail++; $display("FAIL reset outs got %h %h exp 0 0", out0, out1); end
    ntests++;
`ifdef TC_RAM_CLEAR_EN
    if (busy !== 1'b1) begin nfail++; $display("FAIL reset busy got %b exp 1", busy); end
`else
    if (busy !== 1'b0) begin nfail++; $display("FAIL reset busy got %b exp 0", busy); end
`endif
    rst = 0; last0 = 0; last1 = 0; q0.delete(); q1.delete();
`ifdef TC_RAM_CLEAR_EN
    wait_sweep("reset_sweep");
`endif
    drive(0, 2'b00, 0, 0, 1, 8'd199, 0, 0);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== exp0) begin nfail++; $display("FAIL reset_read out0 got %h exp %h", out0, exp0); end
  endtask

  task automatic test_write_read;
    drive(1, 2'b11, 8'h00, 16'h0001, 0, 0, 0, 0);
    exp0 = q0.pop_front(); exp1 = q1.pop_front();
    drive(0, 2'b00, 0, 0, 1, 8'h00, 0, 0);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== exp0) begin nfail++; $display("FAIL write_read out0 got %h exp %h", out0, exp0); end
    drive(1, 2'b11, 8'h01, 16'h0002, 0, 0, 0, 0);
    exp0 = q0.pop_front(); exp1 = q1.pop_front();
    drive(0, 2'b00, 0, 0, 0, 0, 1, 8'h01);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out1 !== exp1) begin nfail++; $display("FAIL write_read out1 got %h exp %h", out1, exp1); end
    ntests++;
    if (out0 !== 16'h0001) begin nfail++; $display("FAIL hold out0 got %h exp 0001", out0); end
  endtask

  task automatic test_byte_mask;
    drive(1, 2'b11, 8'h05, 16'hBEEF, 0, 0, 0, 0);
    drive(1, 2'b10, 8'h05, 16'h1200, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 8'h05, 0, 0);
    repeat (2) begin exp0 = q0.pop_front(); exp1 = q1.pop_front(); end
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== 16'h12EF || out0 !== exp0) begin nfail++; $display("FAIL byte_mask got %h exp 12ef", out0); end
    drive(1, 2'b00, 8'h05, 16'hFFFF, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 0, 0, 1, 8'h05);
    exp0 = q0.pop_front(); exp1 = q1.pop_front();
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out1 !== exp1) begin nfail++; $display("FAIL mask_zero got %h exp %h", out1, exp1); end
  endtask

  task automatic test_rdw;
    drive(1, 2'b11, 8'h10, 16'h005A, 1, 8'h10, 1, 8'h10);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== exp0 || out1 !== exp1) begin nfail++; $display("FAIL rdw got %h %h exp %h %h", out0, out1, exp0, exp1); end
    drive(1, 2'b10, 8'h10, 16'hAA00, 1, 8'h10, 1, 8'h10);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== 16'hAA5A || out0 !== exp0 || out1 !== exp1) begin nfail++; $display("FAIL rdw_merge got %h %h exp %h %h", out0, out1, exp0, exp1); end
  endtask

  task automatic test_boundary;
    drive(1, 2'b11, 8'd199, 16'h1234, 0, 0, 0, 0);
    drive(1, 2'b11, 8'd200, 16'h00FF, 0, 0, 0, 0);
    drive(0, 2'b00, 0, 0, 1, 8'd200, 1, 8'd199);
    repeat (2) begin exp0 = q0.pop_front(); exp1 = q1.pop_front(); end
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== 16'h0 || out0 !== exp0) begin nfail++; $display("FAIL oob_read got %h exp 0000", out0); end
    ntests++;
    if (out1 !== 16'h1234 || out1 !== exp1) begin nfail++; $display("FAIL addr199 got %h exp 1234", out1); end
  endtask

  task automatic test_reset_mid;
`ifdef TC_RAM_CLEAR_EN
    rst = 1; @(posedge clk); #1; rst = 0;
    repeat (100) @(posedge clk);
    #1; rst = 1; @(posedge clk); #1; rst = 0;
    last0 = 0; last1 = 0; q0.delete(); q1.delete();
    wait_sweep("mid_sweep");
    drive(0, 2'b00, 0, 0, 1, 8'd199, 1, 8'h05);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== exp0 || out1 !== exp1) begin nfail++; $display("FAIL cleared got %h %h exp %h %h", out0, out1, exp0, exp1); end
`else
    drive(1, 2'b11, 8'h07, 16'hCAFE, 0, 0, 0, 0);
    rst = 1; repeat (3) @(posedge clk); #1; rst = 0;
    last0 = 0; last1 = 0; q0.delete(); q1.delete();
    drive(0, 2'b00, 0, 0, 1, 8'h07, 1, 8'h05);
    exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
    if (out0 !== 16'hCAFE || out0 !== exp0 || out1 !== exp1) begin nfail++; $display("FAIL survive_rst got %h %h exp %h %h", out0, out1, exp0, exp1); end
`endif
  endtask

  task automatic test_back_to_back;
    for (int k = 0; k < 60; k++) begin
      drive(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(190, 203)),
            16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(190, 203)),
            1'($urandom_range(0, 1)), 8'($urandom_range(190, 203)));
      exp0 = q0.pop_front(); exp1 = q1.pop_front(); ntests++;
      if (out0 !== exp0 || out1 !== exp1) begin nfail++; $display("FAIL b2b[%0d] got %h %h exp %h %h", k, out0, out1, exp0, exp1); end
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_byte_mask;
    test_rdw;
    test_boundary;
    test_back_to_back;
    test_reset_mid;
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end
endmodule
